sum_byte_serializer: RTL and testbench

//  Downstream stage of the 400-bit multi-precision adder. Captures the full-width sum on the adder's done pulse.

---
 rtl/adder_pkg.sv | 15 +
 rtl/sum_byte_serializer.sv | 95 +++++++++
 tb/tb_sum_byte_serializer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Constants and state encoding shared by the 400-bit adder datapath, its control FSM
// and the sum serializer downstream of it.
package adder_pkg;

    localparam int WIDTH  = 400;
    localparam int BYTE_W = 8;
    localparam int NBYTES = WIDTH / BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        SEND = 2'd2
    } ser_state_e;

endpackage

// File: rtl/sum_byte_serializer.sv
// Captures the adder sum on done and streams it MSB-first as bytes over valid/ready.
// Optional macro SUM_SER_LZ_SKIP_EN drops leading zero bytes (byte 0 is always sent).
module sum_byte_serializer #(
    parameter int WIDTH  = adder_pkg::WIDTH,
    parameter int BYTE_W = adder_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  din,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
);
    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NBYTES - 1);

    import adder_pkg::*;

    ser_state_e        state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overrun_q;
    logic              xfer;

    assign xfer = out_valid && out_ready;

    // Next-state logic: cnt counts remaining bytes after the one on the output, so the
    // cnt==0 guard ends the stream before the counter could ever wrap.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = din;
                    cnt_d   = CNT_INIT;
`ifdef SUM_SER_LZ_SKIP_EN
                    state_d = SKIP;
`else
                    state_d = SEND;
`endif
                end
            end
`ifdef SUM_SER_LZ_SKIP_EN
            SKIP: begin
                if (shift_q[WIDTH-1 -: BYTE_W] == '0 && cnt_q != '0) begin
                    shift_d = shift_q << BYTE_W;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    state_d = SEND;
                end
            end
`endif
            SEND: begin
                if (xfer) begin
                    if (cnt_q != '0) begin
                        shift_d = shift_q << BYTE_W;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Any load seen outside IDLE is dropped and flagged one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            overrun_q <= load && (state_q != IDLE);
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? shift_q[WIDTH-1 -: BYTE_W] : '0;
    assign out_last  = out_valid && (cnt_q == '0);
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sum_byte_serializer.sv
// Directed self-checking bench for sum_byte_serializer; covers both builds of SUM_SER_LZ_SKIP_EN.
module tb_sum_byte_serializer;

    localparam int WIDTH  = 400;
    localparam int BYTE_W = 8;
    localparam int NBYTES = 50;

    logic              clk;
    logic              rst;
    logic              load;
    logic [WIDTH-1:0]  din;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              overrun;

    int checks;
    int errors;

    logic [WIDTH-1:0] patA;
    logic [WIDTH-1:0] patB;

    sum_byte_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .din       (din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for the first byte of a stream; a timeout counts as a failure.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s first_valid: got out_valid=%b after %0d cycles, want 1", tag, out_valid, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; out_ready = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%b d=%h l=%b busy=%b ovr=%b, want all 0",
                     out_valid, out_data, out_last, busy, overrun);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    // Full stream with out_ready held high: one byte per cycle, last only on byte 0x32.
    task automatic test_stream;
        out_ready = 1'b1;
        din = patA; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_valid("stream");
        for (int i = 0; i < NBYTES; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i + 1) || out_last !== (i == NBYTES - 1) ||
                busy !== 1'b1 || overrun !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stream_byte%0d: got v=%b d=%h l=%b busy=%b ovr=%b, want v=1 d=%h l=%b busy=1 ovr=0",
                         i, out_valid, out_data, out_last, busy, overrun, 8'(i + 1), (i == NBYTES - 1));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_end: got v=%b busy=%b l=%b, want 0 0 0", out_valid, busy, out_last);
        end
    endtask

    // Ready toggles 1,0,1,0 from the first valid cycle: 50 transfers over 99 cycles.
    task automatic test_backpressure;
        int idx;
        idx = 0;
        out_ready = 1'b0;
        din = patA; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_valid("backpressure");
        for (int cyc = 0; cyc < 2 * NBYTES - 1; cyc++) begin
            out_ready = (cyc % 2 == 0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(idx + 1) || out_last !== (idx == NBYTES - 1)) begin
                errors++;
                $display("[TB] FAIL bp_cycle%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                         cyc, out_valid, out_data, out_last, 8'(idx + 1), (idx == NBYTES - 1));
            end
            if (out_ready) idx++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_end: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    // Loads at byte 10 and on the final transfer are dropped and each flagged once.
    task automatic test_overrun;
        out_ready = 1'b1;
        din = patA; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_valid("overrun");
        for (int i = 0; i < NBYTES; i++) begin
            load = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i + 1) || overrun !== (i == 11)) begin
                errors++;
                $display("[TB] FAIL ovr_byte%0d: got v=%b d=%h ovr=%b, want v=1 d=%h ovr=%b",
                         i, out_valid, out_data, overrun, 8'(i + 1), (i == 11));
            end
            if (i == 10 || i == NBYTES - 1) begin
                din = {WIDTH{1'b1}};
                load = 1'b1;
            end
            @(negedge clk);
        end
        load = 1'b0;
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovr_final: got ovr=%b v=%b busy=%b, want 1 0 0", overrun, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovr_idle: got ovr=%b v=%b busy=%b, want 0 0 0", overrun, out_valid, busy);
        end
    endtask

    // Reset at byte 20 aborts the stream; a fresh load then streams patB in full.
    task automatic test_reset_midstream;
        out_ready = 1'b1;
        din = patA; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_valid("rst_mid");
        repeat (20) @(negedge clk);
        checks++;
        if (out_data !== 8'h15) begin
            errors++;
            $display("[TB] FAIL rst_mid_byte20: got d=%h, want 15", out_data);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_abort: got v=%b busy=%b d=%h l=%b, want 0 0 00 0",
                     out_valid, busy, out_data, out_last);
        end
        din = patB; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_valid("rst_reload");
        for (int i = 0; i < NBYTES; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'hFF - i) || out_last !== (i == NBYTES - 1)) begin
                errors++;
                $display("[TB] FAIL reload_byte%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                         i, out_valid, out_data, out_last, 8'(8'hFF - i), (i == NBYTES - 1));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reload_end: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

`ifdef SUM_SER_LZ_SKIP_EN
    task automatic test_lz_skip;
        out_ready = 1'b1;
        din = '0;
        din[15:0] = 16'h1234;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lz_skip_busy: got busy=%b v=%b, want 1 0", busy, out_valid);
        end
        wait_valid("lz_1234");
        checks++;
        if (out_data !== 8'h12 || out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lz_first: got d=%h l=%b, want 12 0", out_data, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h34 || out_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lz_second: got v=%b d=%h l=%b, want 1 34 1", out_valid, out_data, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lz_end: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
        din = '0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_valid("lz_zero");
        checks++;
        if (out_data !== 8'h00 || out_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lz_zero_byte: got d=%h l=%b, want 00 1", out_data, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lz_zero_end: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask
`else
    // All-zero sum is still sent as 50 bytes, first valid exactly one cycle after load.
    task automatic test_zero;
        out_ready = 1'b1;
        din = '0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h00 || out_last !== (i == NBYTES - 1)) begin
                errors++;
                $display("[TB] FAIL zero_byte%0d: got v=%b d=%h l=%b, want v=1 d=00 l=%b",
                         i, out_valid, out_data, out_last, (i == NBYTES - 1));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_end: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < NBYTES; i++) begin
            patA[WIDTH-1-BYTE_W*i -: BYTE_W] = 8'(i + 1);
            patB[WIDTH-1-BYTE_W*i -: BYTE_W] = 8'(8'hFF - i);
        end
        test_reset;
        test_stream;
        test_backpressure;
        test_overrun;
        test_reset_midstream;
`ifdef SUM_SER_LZ_SKIP_EN
        test_lz_skip;
`else
        test_zero;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
